// File: rtl/uart_rx_if.sv
// Parallel/serial signal bundle between the UART receiver and its surroundings.
// The master side drives the serial line and frame configuration; the slave
// side (the receiver) returns the decoded byte, status pulses and Busy.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_ERR;
   logic                  STOP_ERR;
   logic                  Busy;

   modport master (
      output RX_IN, PAR_EN, PAR_TYP,
      input  P_DATA, DATA_VALID, PAR_ERR, STOP_ERR, Busy
   );

   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP,
      output P_DATA, DATA_VALID, PAR_ERR, STOP_ERR, Busy
   );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit. The serial line is synchronised, a falling
// edge opens a frame, each bit is decided by a 3-sample majority vote around
// mid-bit, and the result is reported one cycle after the stop-bit decision.
module uart_rx #(
   parameter int OVERSAMPLE = 8,
   parameter int DATA_WIDTH = 8
) (
   input logic     clk,
   input logic     reset,
   uart_rx_if.slave bus
);

   localparam int MID = OVERSAMPLE / 2;
   localparam int CW  = $clog2(OVERSAMPLE);
   localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_M1   = CW'(MID - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(MID);
   localparam logic [CW-1:0] CNT_P1   = CW'(MID + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IDX_ZERO = IW'(0);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Two-out-of-three vote over the samples taken around mid-bit.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Parity bit the transmitter should have sent: PAR_TYP=1 gives even
   // parity (bit equals XOR of data), PAR_TYP=0 gives odd parity.
   function automatic logic parity_exp(input logic [DATA_WIDTH-1:0] d,
                                       input logic                  typ);
      return typ ? (^d) : (~^d);
   endfunction

   // Synchroniser and edge-detect registers.
   logic sync1_q;
   logic rx_s_q;
   logic rx_prev_q;

   // Frame engine state.
   state_t                state_q,   state_d;
   logic [CW-1:0]         cnt_q,     cnt_d;
   logic [IW-1:0]         idx_q,     idx_d;
   logic [DATA_WIDTH-1:0] data_q,    data_d;
   logic                  smp0_q,    smp0_d;
   logic                  smp1_q,    smp1_d;
   logic                  pen_q,     pen_d;
   logic                  ptyp_q,    ptyp_d;
   logic                  par_bad_q, par_bad_d;

   // Registered outputs.
   logic [DATA_WIDTH-1:0] pdata_q,   pdata_d;
   logic                  valid_q,   valid_d;
   logic                  perr_q,    perr_d;
   logic                  serr_q,    serr_d;
   logic                  busy_q,    busy_d;

   logic                  bit_s;

   // Bring the asynchronous line into the clock domain; idle-high reset value
   // keeps reset release from looking like a start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= bus.RX_IN;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
      end
   end

   // Frame engine and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= CNT_ZERO;
         idx_q     <= IDX_ZERO;
         data_q    <= {DATA_WIDTH{1'b0}};
         smp0_q    <= 1'b1;
         smp1_q    <= 1'b1;
         pen_q     <= 1'b0;
         ptyp_q    <= 1'b0;
         par_bad_q <= 1'b0;
         pdata_q   <= {DATA_WIDTH{1'b0}};
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         serr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         smp0_q    <= smp0_d;
         smp1_q    <= smp1_d;
         pen_q     <= pen_d;
         ptyp_q    <= ptyp_d;
         par_bad_q <= par_bad_d;
         pdata_q   <= pdata_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         serr_q    <= serr_d;
         busy_q    <= busy_d;
      end
   end

   // Bit value decided at cnt = MID+1 from the two earlier samples and the
   // current one.
   assign bit_s = maj3(smp0_q, smp1_q, rx_s_q);

   // Next-state, sampling and result logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      data_d    = data_q;
      smp0_d    = smp0_q;
      smp1_d    = smp1_q;
      pen_d     = pen_q;
      ptyp_d    = ptyp_q;
      par_bad_d = par_bad_q;
      pdata_d   = pdata_q;
      valid_d   = 1'b0;
      perr_d    = 1'b0;
      serr_d    = 1'b0;

      // Per-bit sample counter and the two early vote samples.
      if (state_q != ST_IDLE) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
         if (cnt_q == CNT_M1) begin
            smp0_d = rx_s_q;
         end else if (cnt_q == CNT_MID) begin
            smp1_d = rx_s_q;
         end else begin
            smp0_d = smp0_q;
         end
      end else begin
         cnt_d = CNT_ZERO;
      end

      case (state_q)
         ST_IDLE: begin
            idx_d = IDX_ZERO;
            // Needs a real 1->0 transition, so a line stuck low after a
            // framing error never retriggers.
            if (rx_prev_q && !rx_s_q) begin
               state_d   = ST_START;
               pen_d     = bus.PAR_EN;
               ptyp_d    = bus.PAR_TYP;
               par_bad_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_START: begin
            if ((cnt_q == CNT_P1) && bit_s) begin
               // Start bit did not hold low through mid-bit: a glitch.
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_DATA;
               idx_d   = IDX_ZERO;
            end else begin
               state_d = ST_START;
            end
         end

         ST_DATA: begin
            if (cnt_q == CNT_P1) begin
               data_d[idx_q] = bit_s;
            end else begin
               data_d = data_q;
            end
            if (cnt_q == CNT_LAST) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = IDX_ZERO;
                  state_d = pen_q ? ST_PARITY : ST_STOP;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               idx_d = idx_q;
            end
         end

         ST_PARITY: begin
            if (cnt_q == CNT_P1) begin
               par_bad_d = (bit_s != parity_exp(data_q, ptyp_q));
            end else begin
               par_bad_d = par_bad_q;
            end
            if (cnt_q == CNT_LAST) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end

         ST_STOP: begin
            // Decide half a bit early so a following start edge is not missed.
            if (cnt_q == CNT_P1) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
               perr_d  = par_bad_q;
               serr_d  = ~bit_s;
               if (bit_s && !par_bad_q) begin
                  pdata_d = data_q;
                  valid_d = 1'b1;
               end else begin
                  pdata_d = pdata_q;
               end
            end else begin
               state_d = ST_STOP;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            idx_d   = IDX_ZERO;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign bus.P_DATA     = pdata_q;
   assign bus.DATA_VALID = valid_q;
   assign bus.PAR_ERR    = perr_q;
   assign bus.STOP_ERR   = serr_q;
   assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Each phase builds a per-clock waveform for
// RX_IN, a frame-level reference decoder turns it into expected per-cycle
// outputs, and a compare process checks the DUT against those every cycle.
module tb_uart_rx;

   localparam int OS   = 8;
   localparam int MID  = OS / 2;
   localparam int MAXT = 4000;

   logic clk;
   logic reset;

   uart_rx_if #(.DATA_WIDTH(8)) bus ();

   uart_rx #(.OVERSAMPLE(OS), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Stimulus waveform: line_a[t] is the RX_IN value sampled by edge t.
   logic       line_a    [0:MAXT-1];
   int         tlen;
   bit         m_pen;
   bit         m_ptyp;

   // Expected outputs during cycle t (interval following edge t).
   logic       exp_valid [0:MAXT-1];
   logic       exp_perr  [0:MAXT-1];
   logic       exp_serr  [0:MAXT-1];
   logic       exp_busy  [0:MAXT-1];
   logic [7:0] exp_pdata [0:MAXT-1];
   logic       upd_v     [0:MAXT-1];
   logic [7:0] upd_d     [0:MAXT-1];

   int n_checks;
   int n_fail;
   bit chk_on;
   int ccnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string nm, input int cyc,
                            input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- waveform construction ----------------
   task automatic clear_line();
      tlen = 0;
   endtask

   task automatic add_level(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         line_a[tlen] = v;
         tlen++;
      end
   endtask

   task automatic add_frame(input logic [7:0] d, input bit pflip,
                            input bit stopb, output int p);
      logic pb;
      p = tlen;
      add_level(1'b0, OS);
      for (int i = 0; i < 8; i++) add_level(d[i], OS);
      if (m_pen) begin
         pb = (m_ptyp ? (^d) : ~(^d)) ^ pflip;
         add_level(pb, OS);
      end
      add_level(stopb, OS);
   endtask

   // ---------------- reference model ----------------
   function automatic logic ln(input int i);
      if (i < 0 || i >= tlen) return 1'b1;
      return line_a[i];
   endfunction

   // Vote for line bit k of a frame whose first START cycle is s. The
   // synchronised line in cycle c equals the RX_IN sample from edge c-1.
   function automatic logic maj(input int s, input int k);
      int c0;
      int ones;
      c0 = s + k * OS + MID - 1;
      ones = int'(ln(c0 - 1)) + int'(ln(c0)) + int'(ln(c0 + 1));
      return (ones >= 2);
   endfunction

   task automatic build_model();
      int t;
      int s;
      int nb;
      logic [7:0] d;
      logic [7:0] pd;
      logic stp;
      logic pbad;
      for (int c = 0; c < tlen; c++) begin
         exp_valid[c] = 1'b0; exp_perr[c] = 1'b0; exp_serr[c] = 1'b0;
         exp_busy[c]  = 1'b0; upd_v[c] = 1'b0; upd_d[c] = 8'h00;
      end
      t = 0;
      while (t < tlen) begin
         if (ln(t - 2) && !ln(t - 1)) begin
            s = t + 1;
            if (maj(s, 0)) begin
               for (int c = s; c <= s + MID + 1 && c < tlen; c++) exp_busy[c] = 1'b1;
               t = s + MID + 2;
            end else begin
               for (int i = 0; i < 8; i++) d[i] = maj(s, i + 1);
               nb = m_pen ? 10 : 9;
               pbad = 1'b0;
               if (m_pen) pbad = (maj(s, 9) != (m_ptyp ? (^d) : ~(^d)));
               stp = maj(s, nb);
               t = s + nb * OS + MID + 2;
               for (int c = s; c < t && c < tlen; c++) exp_busy[c] = 1'b1;
               if (t < tlen) begin
                  exp_valid[t] = stp && !pbad;
                  exp_perr[t]  = pbad;
                  exp_serr[t]  = !stp;
                  upd_v[t]     = stp && !pbad;
                  upd_d[t]     = d;
               end
            end
         end else begin
            t++;
         end
      end
      pd = 8'h00;
      for (int c = 0; c < tlen; c++) begin
         if (upd_v[c]) pd = upd_d[c];
         exp_pdata[c] = pd;
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         if (ccnt < tlen) begin
            check_val("DATA_VALID", ccnt, {7'd0, bus.DATA_VALID}, {7'd0, exp_valid[ccnt]});
            check_val("PAR_ERR",    ccnt, {7'd0, bus.PAR_ERR},    {7'd0, exp_perr[ccnt]});
            check_val("STOP_ERR",   ccnt, {7'd0, bus.STOP_ERR},   {7'd0, exp_serr[ccnt]});
            check_val("Busy",       ccnt, {7'd0, bus.Busy},       {7'd0, exp_busy[ccnt]});
            check_val("P_DATA",     ccnt, bus.P_DATA,             exp_pdata[ccnt]);
         end
         ccnt++;
      end
   end

   task automatic check_reset_outputs(input string nm);
      check_val({nm, "_P_DATA"},     0, bus.P_DATA, 8'h00);
      check_val({nm, "_DATA_VALID"}, 0, {7'd0, bus.DATA_VALID}, 8'h00);
      check_val({nm, "_PAR_ERR"},    0, {7'd0, bus.PAR_ERR}, 8'h00);
      check_val({nm, "_STOP_ERR"},   0, {7'd0, bus.STOP_ERR}, 8'h00);
      check_val({nm, "_Busy"},       0, {7'd0, bus.Busy}, 8'h00);
   endtask

   // Reset, then play line_a; abort_at > 0 asserts reset mid-run at that step.
   task automatic run_phase(input int abort_at);
      bus.PAR_EN  = m_pen;
      bus.PAR_TYP = m_ptyp;
      @(posedge clk); #2;
      reset = 1'b1;
      bus.RX_IN = 1'b1;
      #1;
      check_reset_outputs("reset_state");
      @(posedge clk); #2;
      reset = 1'b0;
      bus.RX_IN = line_a[0];
      @(posedge clk); #2;
      ccnt = 0;
      chk_on = 1'b1;
      for (int t = 1; t < tlen; t++) begin
         if (t == abort_at) begin
            chk_on = 1'b0;
            #1 reset = 1'b1;
            #1;
            check_reset_outputs("midframe_reset");
            break;
         end
         bus.RX_IN = line_a[t];
         @(posedge clk); #2;
      end
      chk_on = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int p2;
      int pg;
      int nfr;
      int r;
      int nbits;
      logic [7:0] d;
      n_checks = 0;
      n_fail   = 0;
      chk_on   = 1'b0;
      ccnt     = 0;
      reset    = 1'b1;
      bus.RX_IN = 1'b1;
      bus.PAR_EN = 1'b0;
      bus.PAR_TYP = 1'b0;

      // Reset mid-frame after a good byte was received.
      m_pen = 1'b0; m_ptyp = 1'b0;
      clear_line();
      add_level(1'b1, 6); add_frame(8'h33, 1'b0, 1'b1, p);
      add_level(1'b1, 4); add_frame(8'h77, 1'b0, 1'b1, p2);
      add_level(1'b1, 10);
      build_model();
      check_val("pin_pre_reset_pdata", p + 80, exp_pdata[p + 80], 8'h33);
      run_phase(p2 + 40);

      // Clean 0x5A after reset.
      clear_line();
      add_level(1'b1, 5); add_frame(8'h5A, 1'b0, 1'b1, p); add_level(1'b1, 10);
      build_model();
      check_val("pin_5a_pdata", p + 80, exp_pdata[p + 80], 8'h5A);
      run_phase(0);

      // 0xA5, no parity: pulse at S+78, Busy S..S+77.
      clear_line();
      add_level(1'b1, 7); add_frame(8'hA5, 1'b0, 1'b1, p); add_level(1'b1, 12);
      build_model();
      check_val("pin_a5_valid", p + 80, {7'd0, exp_valid[p + 80]}, 8'h01);
      check_val("pin_a5_valid_early", p + 79, {7'd0, exp_valid[p + 79]}, 8'h00);
      check_val("pin_a5_busy_first", p + 2, {7'd0, exp_busy[p + 2]}, 8'h01);
      check_val("pin_a5_busy_pre", p + 1, {7'd0, exp_busy[p + 1]}, 8'h00);
      check_val("pin_a5_busy_last", p + 79, {7'd0, exp_busy[p + 79]}, 8'h01);
      check_val("pin_a5_busy_end", p + 80, {7'd0, exp_busy[p + 80]}, 8'h00);
      check_val("pin_a5_pdata", p + 80, exp_pdata[p + 80], 8'hA5);
      run_phase(0);

      // Parity enabled, PAR_TYP=1: 0x3C parity 0 good, parity 1 error.
      m_pen = 1'b1; m_ptyp = 1'b1;
      clear_line();
      add_level(1'b1, 5); add_frame(8'h3C, 1'b0, 1'b1, p);
      add_level(1'b1, 8); add_frame(8'h3C, 1'b1, 1'b1, p2);
      add_level(1'b1, 10);
      build_model();
      check_val("pin_par_valid", p + 88, {7'd0, exp_valid[p + 88]}, 8'h01);
      check_val("pin_par_err", p2 + 88, {7'd0, exp_perr[p2 + 88]}, 8'h01);
      check_val("pin_par_no_valid", p2 + 88, {7'd0, exp_valid[p2 + 88]}, 8'h00);
      check_val("pin_par_pdata_hold", p2 + 88, exp_pdata[p2 + 88], 8'h3C);
      run_phase(0);

      // Stop bit 0, line held low, then a fresh frame.
      m_pen = 1'b0; m_ptyp = 1'b0;
      clear_line();
      add_level(1'b1, 5); add_frame(8'h81, 1'b0, 1'b0, p);
      add_level(1'b0, 40); add_level(1'b1, 10);
      add_frame(8'h42, 1'b0, 1'b1, p2); add_level(1'b1, 10);
      build_model();
      check_val("pin_stop_err", p + 80, {7'd0, exp_serr[p + 80]}, 8'h01);
      check_val("pin_stop_no_valid", p + 80, {7'd0, exp_valid[p + 80]}, 8'h00);
      check_val("pin_stop_idle_low", p + 110, {7'd0, exp_busy[p + 110]}, 8'h00);
      check_val("pin_stop_pdata", p + 80, exp_pdata[p + 80], 8'h00);
      check_val("pin_after_stop_pdata", p2 + 80, exp_pdata[p2 + 80], 8'h42);
      run_phase(0);

      // Start-bit glitch, then 0x0F with a flipped sample at cnt=MID of bit 2.
      clear_line();
      add_level(1'b1, 5); pg = tlen; add_level(1'b0, 2); add_level(1'b1, 10);
      add_frame(8'h0F, 1'b0, 1'b1, p); add_level(1'b1, 10);
      line_a[p + 3 * OS + MID + 1] = ~line_a[p + 3 * OS + MID + 1];
      build_model();
      check_val("pin_glitch_busy_end", pg + 2 + MID + 1, {7'd0, exp_busy[pg + 2 + MID + 1]}, 8'h01);
      check_val("pin_glitch_idle", pg + 2 + MID + 2, {7'd0, exp_busy[pg + 2 + MID + 2]}, 8'h00);
      check_val("pin_0f_pdata", p + 80, exp_pdata[p + 80], 8'h0F);
      run_phase(0);

      // Back-to-back 0x01 and 0xFF with no idle gap.
      clear_line();
      add_level(1'b1, 5); add_frame(8'h01, 1'b0, 1'b1, p);
      add_frame(8'hFF, 1'b0, 1'b1, p2); add_level(1'b1, 10);
      build_model();
      check_val("pin_b2b_first", p + 80, exp_pdata[p + 80], 8'h01);
      check_val("pin_b2b_second_valid", p + 160, {7'd0, exp_valid[p + 160]}, 8'h01);
      check_val("pin_b2b_second", p + 160, exp_pdata[p + 160], 8'hFF);
      run_phase(0);

      // Randomised phases.
      for (int ph = 0; ph < 6; ph++) begin
         m_pen  = ($urandom % 2) == 1;
         m_ptyp = ($urandom % 2) == 1;
         clear_line();
         add_level(1'b1, $urandom_range(2, 10));
         nfr = 12;
         for (int f = 0; f < nfr; f++) begin
            r = $urandom % 10;
            if (r == 0) begin
               add_level(1'b0, $urandom_range(1, 3));
               add_level(1'b1, $urandom_range(3, 12));
            end else begin
               d = 8'($urandom);
               add_frame(d, ($urandom % 6) == 0, ($urandom % 7) != 0, p);
               nbits = m_pen ? 11 : 10;
               if (($urandom % 4) == 0) begin
                  pg = p + $urandom_range(0, nbits * OS - 1);
                  line_a[pg] = ~line_a[pg];
               end
               if (($urandom % 3) != 0) add_level(1'b1, $urandom_range(1, 15));
            end
         end
         add_level(1'b1, 20);
         build_model();
         run_phase(0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the receive-side counterpart of the team's UART transmitter frame format: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1). It synchronises the serial line, detects and qualifies the start bit, majority-votes three mid-bit samples per bit, and delivers each parallel byte with a one-cycle valid strobe plus parity and framing error pulses. It sits between the pad-side serial input and the parallel consumer in the UART subsystem.

## Interface
- OVERSAMPLE, 8: clk cycles per bit; even, 4..32. MID = OVERSAMPLE/2.
- DATA_WIDTH, 8: data bits per frame.

- clk  in  1  receiver clock, OVERSAMPLE × bit rate.
- reset  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line, idle high, asynchronous to clk.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  parity rule select, see Operation.
- P_DATA  out  DATA_WIDTH  last good received byte.
- DATA_VALID  out  1  one-cycle pulse: P_DATA updated with a good frame.
- PAR_ERR  out  1  one-cycle pulse: parity mismatch.
- STOP_ERR  out  1  one-cycle pulse: stop bit sampled 0.
- Busy  out  1  high while a frame is being received.

## Operation
- RX_IN passes through a 2-flop synchroniser (reset value 1) into rx_s; a third register holds rx_s_d for falling-edge detection.
- States IDLE, START, DATA, PARITY, STOP. Sample counter cnt runs 0..OVERSAMPLE-1 per bit; bit index idx 0..DATA_WIDTH-1.
- Bit value = majority of rx_s at cnt = MID-1, MID, MID+1; decided at cnt = MID+1.
- IDLE: on rx_s_d=1 and rx_s=0 -> START, cnt=0; PAR_EN and PAR_TYP latched here and held for the frame.
- START: if decided value is 1 -> glitch, return to IDLE, no output pulses. Else at cnt=OVERSAMPLE-1 -> DATA, idx=0.
- DATA: decided bit written to data_reg[idx]; at cnt=OVERSAMPLE-1 idx increments; after idx=DATA_WIDTH-1 -> PARITY if latched PAR_EN else STOP.
- PARITY: expected bit = ~^data_reg when PAR_TYP=0, ^data_reg when PAR_TYP=1; mismatch flagged. At cnt=OVERSAMPLE-1 -> STOP.
- STOP: at cnt=MID+1 decide stop bit and return to IDLE immediately (half-bit early, so back-to-back frames are caught). Next cycle:
  - stop=1, parity OK: P_DATA <= data_reg, DATA_VALID=1.
  - parity mismatch: PAR_ERR=1; P_DATA holds.
  - stop=0: STOP_ERR=1; P_DATA holds. PAR_ERR and STOP_ERR may pulse together.
- After a stop error, a new frame starts only on a fresh 1->0 edge of rx_s (line held low never retriggers).
- Busy = 1 in START, DATA, PARITY, STOP; 0 in IDLE.

## Timing
- Reset (async, any cycle, including mid-frame): state IDLE, cnt=idx=0, P_DATA=0, DATA_VALID=PAR_ERR=STOP_ERR=Busy=0, sync flops=1. Partial frame discarded, no pulses.
- S = first cycle in START with cnt=0 = 3 clk edges after the first edge sampling RX_IN low.
- Line bit k (k=0 start) maps to cycles S+k·OVERSAMPLE .. S+(k+1)·OVERSAMPLE-1.
- Result pulse in cycle S + N·OVERSAMPLE + MID + 2, N = 9 (no parity) or 10 (parity). OVERSAMPLE=8: S+78 / S+86.
- Busy high from S through S + N·OVERSAMPLE + MID + 1; low in the pulse cycle.
- Pulses last exactly one cycle; P_DATA stable between DATA_VALID pulses.
- Start-bit glitch: Busy high S..S+MID+1, IDLE at S+MID+2.
- Minimum inter-frame gap: zero idle bits.

## Test plan
- Reset asserted mid-frame -> all outputs 0, P_DATA=0x00 immediately; next clean frame 0x5A received normally.
- OVERSAMPLE=8, PAR_EN=0, frame 0xA5 -> P_DATA=0xA5, DATA_VALID at S+78 only, Busy high S..S+77, no error pulses.
- PAR_EN=1, PAR_TYP=1, 0x3C with parity bit 0 -> DATA_VALID at S+86; repeat with parity bit 1 -> PAR_ERR at S+86, no DATA_VALID, P_DATA stays 0x3C.
- Frame 0x81 with stop bit 0, line then held low 40 cycles -> STOP_ERR once, P_DATA unchanged, Busy stays 0 until line returns high and falls again.
- RX_IN low for 2 cycles then high -> Busy pulse ending at S+MID+1, no DATA_VALID/PAR_ERR/STOP_ERR; one-sample inverted glitch at cnt=MID of a data bit in 0x0F -> still received as 0x0F.
- Back-to-back frames 0x01 then 0xFF, no idle gap, PAR_EN=0 -> two DATA_VALID pulses 80 cycles apart with P_DATA 0x01 then 0xFF.
